// File: rtl/reg_dump.sv
// reg_dump: walks register indices FIRST_REG..LAST_REG, reads each from an
// external register file and emits it as a valid/ready word stream.
// Optional trailing XOR checksum word is compiled in with REG_DUMP_CHECKSUM_EN.
module reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  reg_address,
    input  logic [31:0] data_out,
    output logic [31:0] dump_data,
    output logic [4:0]  dump_addr,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(LAST_REG);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] w_addr;
    logic              w_valid;
    logic              w_last;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] w_csum;
`endif

    // Next-state, read address and next output values
    always_comb begin
        w_next_state = r_state;
        w_ptr        = r_ptr;
        w_data       = dump_data;
        w_addr       = dump_addr;
        w_valid      = dump_valid;
        w_last       = dump_last;
        reg_address  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
        w_csum       = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ptr        = LP_FIRST;
`ifdef REG_DUMP_CHECKSUM_EN
                    w_csum       = '0;
`endif
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                reg_address  = r_ptr;
                w_data       = data_out;
                w_addr       = r_ptr;
                w_valid      = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                w_last       = 1'b0;
                w_csum       = r_csum ^ data_out;
`else
                w_last       = (r_ptr == LP_LAST);
`endif
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (dump_valid && dump_ready) begin
                    w_valid = 1'b0;
                    if (r_ptr == LP_LAST) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // Checksum already folds in the final register word
                        w_data       = r_csum;
                        w_addr       = '0;
                        w_valid      = 1'b1;
                        w_last       = 1'b1;
                        w_next_state = S_CSUM;
`else
                        w_next_state = S_DONE;
`endif
                    end else begin
                        w_ptr        = r_ptr + ADDR_W'(1);
                        w_next_state = S_READ;
                    end
                end
            end
            S_CSUM: begin
`ifdef REG_DUMP_CHECKSUM_EN
                if (dump_valid && dump_ready) begin
                    w_valid      = 1'b0;
                    w_next_state = S_DONE;
                end
`else
                w_next_state = S_IDLE;
`endif
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_ptr      <= w_ptr;
            dump_data  <= w_data;
            dump_addr  <= w_addr;
            dump_valid <= w_valid;
            dump_last  <= w_last;
            busy       <= (w_next_state != S_IDLE);
            done       <= (w_next_state == S_DONE);
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum     <= w_csum;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: full-range dump, backpressure, mid-dump reset and a
// single-register instance. Follows REG_DUMP_CHECKSUM_EN when defined.
module tb_reg_dump;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  reg_address;
    logic [31:0] data_out;
    logic [31:0] dump_data;
    logic [4:0]  dump_addr;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_last;
    logic        busy;
    logic        done;

    logic        s_start;
    logic [4:0]  s_reg_address;
    logic [31:0] s_data_out;
    logic [31:0] s_dump_data;
    logic [4:0]  s_dump_addr;
    logic        s_dump_valid;
    logic        s_dump_ready;
    logic        s_dump_last;
    logic        s_busy;
    logic        s_done;

    logic [31:0] rf  [32];
    logic [31:0] rf1 [32];
    vec_t        tbl [33];
    int          n_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_out   = rf[reg_address];
    assign s_data_out = rf1[s_reg_address];

    reg_dump u_dut (
        .clk(clk), .reset(reset), .start(start), .reg_address(reg_address),
        .data_out(data_out), .dump_data(dump_data), .dump_addr(dump_addr),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_last(dump_last),
        .busy(busy), .done(done)
    );

    reg_dump #(.FIRST_REG(3), .LAST_REG(3)) u_one (
        .clk(clk), .reset(reset), .start(s_start), .reg_address(s_reg_address),
        .data_out(s_data_out), .dump_data(s_dump_data), .dump_addr(s_dump_addr),
        .dump_valid(s_dump_valid), .dump_ready(s_dump_ready), .dump_last(s_dump_last),
        .busy(s_busy), .done(s_done)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dump on the default instance, optionally stalling word stall_idx for 3 cycles
    task automatic run_dump(input int stall_idx);
        int          prev_cyc;
        int          guard;
        logic [31:0] saved;
        prev_cyc   = 0;
        dump_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk("lat_valid_lo", 32'(dump_valid), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_valid_hi", 32'(dump_valid), 32'd1);
        for (int k = 0; k < n_exp; k++) begin
            guard = 0;
            while (!dump_valid && guard < 8) begin
                tick();
                guard++;
            end
            if (!dump_valid) begin
                n_checks++;
                n_fail++;
                $display("FAIL word_timeout: word %0d never became valid", k);
                return;
            end
            chk($sformatf("addr[%0d]", k), 32'(dump_addr), 32'(tbl[k].addr));
            chk($sformatf("data[%0d]", k), dump_data, tbl[k].data);
            chk($sformatf("last[%0d]", k), 32'(dump_last), 32'(tbl[k].last));
            if (k > 0 && (k - 1) != stall_idx)
                chk($sformatf("spacing[%0d]", k), 32'(cyc - prev_cyc), 32'd2);
            prev_cyc = cyc;
            if (k == stall_idx) begin
                dump_ready = 1'b0;
                saved = rf[tbl[k].addr];
                rf[tbl[k].addr] = 32'hDEAD_0000;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_valid", 32'(dump_valid), 32'd1);
                    chk("stall_data", dump_data, tbl[k].data);
                    chk("stall_addr", 32'(dump_addr), 32'(tbl[k].addr));
                    chk("stall_last", 32'(dump_last), 32'(tbl[k].last));
                end
                rf[tbl[k].addr] = saved;
                dump_ready = 1'b1;
            end
            tick();
            chk("valid_drop", 32'(dump_valid), 32'd0);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_extra_word", 32'(dump_valid), 32'd0);
        end
    endtask

    initial begin
        int          guard;
        int          n_done;
        logic [31:0] csum;

        // Expected word table for the default instance
        for (int i = 0; i < 32; i++) begin
            rf[i]  = 32'd0;
            rf1[i] = 32'h1000 + 32'(i);
        end
        rf[5]  = 32'hAABB_CCDD;
        rf[10] = 32'h1234_5678;
        rf1[3] = 32'h0000_BEEF;
        csum   = 32'd0;
        for (int i = 0; i < 32; i++) begin
            tbl[i].addr = 5'(i);
            tbl[i].data = rf[i];
            tbl[i].last = (i == 31);
            csum = csum ^ rf[i];
        end
        n_exp = 32;
`ifdef REG_DUMP_CHECKSUM_EN
        tbl[31].last = 1'b0;
        tbl[32].addr = 5'd0;
        tbl[32].data = csum;
        tbl[32].last = 1'b1;
        n_exp = 33;
`endif

        reset        = 1'b1;
        start        = 1'b0;
        dump_ready   = 1'b0;
        s_start      = 1'b0;
        s_dump_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", dump_data, 32'd0);
        chk("rst_regaddr", 32'(reg_address), 32'd0);
        tick();
        chk("idle_no_word", 32'(dump_valid), 32'd0);

        // Full dump, ready held high
        run_dump(-1);
        // Full dump, addr-5 word stalled 3 cycles with a register write underneath
        run_dump(5);

        // Reset while stalled in HOLD at ptr=7
        dump_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        guard      = 0;
        while (!(dump_valid && dump_addr == 5'd7) && guard < 40) begin
            tick();
            guard++;
        end
        dump_ready = 1'b0;
        chk("rst_reach7", 32'(dump_addr), 32'd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_valid", 32'(dump_valid), 32'd0);
        chk("midrst_last", 32'(dump_last), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", dump_data, 32'd0);
        chk("midrst_addr", 32'(dump_addr), 32'd0);
        chk("midrst_regaddr", 32'(reg_address), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_quiet", 32'(dump_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        run_dump(-1);

        // Single-register instance; start held through READ and HOLD
        s_dump_ready = 1'b0;
        s_start      = 1'b1;
        tick();
        chk("one_busy", 32'(s_busy), 32'd1);
        chk("one_valid_lo", 32'(s_dump_valid), 32'd0);
        tick();
        chk("one_valid", 32'(s_dump_valid), 32'd1);
        chk("one_data", s_dump_data, 32'h0000_BEEF);
        chk("one_addr", 32'(s_dump_addr), 32'd3);
`ifdef REG_DUMP_CHECKSUM_EN
        chk("one_last", 32'(s_dump_last), 32'd0);
`else
        chk("one_last", 32'(s_dump_last), 32'd1);
`endif
        tick();
        chk("one_hold", s_dump_data, 32'h0000_BEEF);
        s_start      = 1'b0;
        s_dump_ready = 1'b1;
        tick();
`ifdef REG_DUMP_CHECKSUM_EN
        chk("one_csum_data", s_dump_data, 32'h0000_BEEF);
        chk("one_csum_addr", 32'(s_dump_addr), 32'd0);
        chk("one_csum_last", 32'(s_dump_last), 32'd1);
        tick();
`endif
        chk("one_done", 32'(s_done), 32'd1);
        chk("one_valid_off", 32'(s_dump_valid), 32'd0);
        tick();
        chk("one_done_clear", 32'(s_done), 32'd0);
        chk("one_idle", 32'(s_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("one_quiet", 32'(s_dump_valid), 32'd0);
        end

        // start held high: each DONE returns to IDLE and immediately restarts
        s_start = 1'b1;
        n_done  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_done) n_done++;
        end
`ifdef REG_DUMP_CHECKSUM_EN
        chk("held_start_dumps", 32'(n_done), 32'd2);
`else
        chk("held_start_dumps", 32'(n_done), 32'd3);
`endif
        s_start = 1'b0;
        guard   = 0;
        while (s_busy && guard < 10) begin
            tick();
            guard++;
        end
        chk("held_start_end", 32'(s_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
